// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the VGA test-pattern generator.
//   mode_e       : applied/requested pattern mode encodings
//   colour_max() : full-scale value of an N-bit colour channel
//   BAR_RGB      : colour-bar table, one on/off bit per channel, bar 0 first
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_CHART   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SCROLL  = 2'd3
  } mode_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } bar_rgb_t;

  localparam bar_rgb_t BAR_WHITE   = 3'b111;
  localparam bar_rgb_t BAR_YELLOW  = 3'b110;
  localparam bar_rgb_t BAR_CYAN    = 3'b011;
  localparam bar_rgb_t BAR_GREEN   = 3'b010;
  localparam bar_rgb_t BAR_MAGENTA = 3'b101;
  localparam bar_rgb_t BAR_RED     = 3'b100;
  localparam bar_rgb_t BAR_BLUE    = 3'b001;
  localparam bar_rgb_t BAR_BLACK   = 3'b000;

  localparam bar_rgb_t BAR_RGB [8] = '{BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
                                       BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK};

  function automatic int unsigned colour_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream interface between VGA_Controller and vga_pattern_gen.
//   i_X/i_Y, i_Mode/i_Mode_Load : coordinate and mode request (master -> slave)
//   o_Red/o_Grn/o_Blu           : registered pixel colour (slave -> master)
//   o_Col/o_Row/o_Mode/o_Frame  : stage-1 tile position, applied mode, frame count
interface vga_pattern_gen_if #(
  parameter int unsigned COLOR_BITS = 3,
  parameter int unsigned COORD_BITS = 12
);
  logic [COORD_BITS-1:0] i_X;
  logic [COORD_BITS-1:0] i_Y;
  logic [1:0]            i_Mode;
  logic                  i_Mode_Load;
  logic [COLOR_BITS-1:0] o_Red;
  logic [COLOR_BITS-1:0] o_Grn;
  logic [COLOR_BITS-1:0] o_Blu;
  logic [7:0]            o_Col;
  logic [7:0]            o_Row;
  logic [1:0]            o_Mode;
  logic [7:0]            o_Frame;

  modport master (
    output i_X, i_Y, i_Mode, i_Mode_Load,
    input  o_Red, o_Grn, o_Blu, o_Col, o_Row, o_Mode, o_Frame
  );

  modport slave (
    input  i_X, i_Y, i_Mode, i_Mode_Load,
    output o_Red, o_Grn, o_Blu, o_Col, o_Row, o_Mode, o_Frame
  );
endinterface

// File: rtl/vga_tile_counter.sv
// Tile index counter: a sub-counter runs 0..TILE_SIZE-1 and bumps the tile
// index on wrap, so no divider is needed.
//   i_Clk, w_Reset : clock, synchronous active-high reset
//   clr_i          : restart at tile 0 (wins over adv_i)
//   adv_i          : advance by one pixel/line
//   count_o        : registered tile index (wraps at 2^COUNT_W)
module vga_tile_counter #(
  parameter int unsigned TILE_SIZE = 20,
  parameter int unsigned COUNT_W   = 8
) (
  input  logic               i_Clk,
  input  logic               w_Reset,
  input  logic               clr_i,
  input  logic               adv_i,
  output logic [COUNT_W-1:0] count_o
);
  localparam int unsigned SUB_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TILE_SIZE - 1);

  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Next-state: clear, else step the sub-counter and carry into the index
  always_comb begin
    sub_d   = sub_q;
    count_d = count_q;
    if (clr_i) begin
      sub_d   = '0;
      count_d = '0;
    end else if (adv_i) begin
      if (sub_q == SUB_LAST) begin
        sub_d   = '0;
        count_d = count_q + COUNT_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_Reset) begin
      sub_q   <= '0;
      count_q <= '0;
    end else begin
      sub_q   <= sub_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern generator, fixed 2-cycle coordinate-to-colour
// latency. Stage 1 registers tile col/row, active flag, applied mode and frame
// count; stage 2 registers the colour.
//   i_Clk, w_Reset : pixel clock, synchronous active-high reset
//   bus (slave)    : coordinates/mode request in, colour and status out
// Optional macro VGA_PATTERN_BORDER_EN: paints a full-scale one-pixel border
// around the active area, overriding every mode.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int unsigned COLOR_BITS = 3,
  parameter int unsigned COORD_BITS = 12,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned TILE_W     = 20,
  parameter int unsigned TILE_H     = 30
) (
  input logic          i_Clk,
  input logic          w_Reset,
  vga_pattern_gen_if.slave bus
);
  localparam int unsigned SCROLL_W   = COLOR_BITS + 2;
  localparam int unsigned CHART_COLS = 2 ** (COLOR_BITS + 2);
  localparam int unsigned CHART_ROWS = 2 ** (COLOR_BITS + 1);
  localparam logic [COLOR_BITS-1:0] FULL = COLOR_BITS'(colour_max(COLOR_BITS));

  logic x_zero_c, y_zero_c, frame_start_c, active_c;
  logic [7:0] col_q, row_q;
  mode_e      pend_q, pend_d, mode_q, mode_d;
  logic [7:0] frame_q, frame_d;
  logic       active1_q;
  logic [SCROLL_W-1:0]   scroll_col_c;
  logic [COLOR_BITS-1:0] red_q, grn_q, blu_q, red_d, grn_d, blu_d;
  bar_rgb_t   bar_c;

  assign x_zero_c      = (bus.i_X == '0);
  assign y_zero_c      = (bus.i_Y == '0);
  assign frame_start_c = x_zero_c && y_zero_c;
  assign active_c      = (bus.i_X < COORD_BITS'(H_ACTIVE)) && (bus.i_Y < COORD_BITS'(V_ACTIVE));

`ifdef VGA_PATTERN_BORDER_EN
  logic border_c, border1_q;
  assign border_c = x_zero_c || y_zero_c ||
                    (bus.i_X == COORD_BITS'(H_ACTIVE - 1)) ||
                    (bus.i_Y == COORD_BITS'(V_ACTIVE - 1));
`endif

  // Columns advance every pixel and restart each line
  vga_tile_counter #(.TILE_SIZE(TILE_W), .COUNT_W(8)) u_col_cnt (
    .i_Clk   (i_Clk),
    .w_Reset (w_Reset),
    .clr_i   (x_zero_c),
    .adv_i   (1'b1),
    .count_o (col_q)
  );

  // Rows advance once per line and restart each frame
  vga_tile_counter #(.TILE_SIZE(TILE_H), .COUNT_W(8)) u_row_cnt (
    .i_Clk   (i_Clk),
    .w_Reset (w_Reset),
    .clr_i   (frame_start_c),
    .adv_i   (x_zero_c),
    .count_o (row_q)
  );

  // Mode request is held pending; frame start applies the value pending before
  // this cycle, so a strobe on the frame-start cycle lands one frame later.
  always_comb begin
    pend_d  = pend_q;
    mode_d  = mode_q;
    frame_d = frame_q;
    if (bus.i_Mode_Load) pend_d = mode_e'(bus.i_Mode);
    if (frame_start_c) begin
      mode_d  = pend_q;
      frame_d = frame_q + 8'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_Reset) begin
      pend_q    <= MODE_CHART;
      mode_q    <= MODE_CHART;
      frame_q   <= '0;
      active1_q <= 1'b0;
`ifdef VGA_PATTERN_BORDER_EN
      border1_q <= 1'b0;
`endif
    end else begin
      pend_q    <= pend_d;
      mode_q    <= mode_d;
      frame_q   <= frame_d;
      active1_q <= active_c;
`ifdef VGA_PATTERN_BORDER_EN
      border1_q <= border_c;
`endif
    end
  end

  // Colour chart: 4 bands of tiles in two halves; outside the chart is black
  function automatic logic [3*COLOR_BITS-1:0] chart_rgb(input logic [7:0] col,
                                                        input logic [7:0] row);
    logic [COLOR_BITS-1:0] lo, lr, r, g, b;
    logic [1:0] band;
    logic       half;
    lo   = col[COLOR_BITS-1:0];
    lr   = row[COLOR_BITS-1:0];
    band = col[COLOR_BITS+1:COLOR_BITS];
    half = row[COLOR_BITS];
    r = '0;
    g = '0;
    b = '0;
    if (half) begin
      r = lr;
      case (band)
        2'd0:    g = lo;
        2'd1:    begin g = FULL; b = lo;   end
        2'd2:    begin g = ~lo;  b = FULL; end
        default: b = ~lo;
      endcase
    end else begin
      case (band)
        2'd0:    begin g = lo;  b = ~lr; end
        2'd1:    begin g = ~lo; b = lr;  end
        2'd2:    begin g = lr;  b = lr;  end
        default: begin g = ~lr; b = ~lo; end
      endcase
    end
    if (32'(col) >= CHART_COLS || 32'(row) >= CHART_ROWS) begin
      r = '0;
      g = '0;
      b = '0;
    end
    return {r, g, b};
  endfunction

  // Scroll offset is frame/4, applied modulo the chart width
  assign scroll_col_c = col_q[SCROLL_W-1:0] + SCROLL_W'(frame_q[7:2]);
  assign bar_c        = BAR_RGB[col_q[4:2]];

  // Stage-2 colour select
  always_comb begin
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    case (mode_q)
      MODE_CHART:  {red_d, grn_d, blu_d} = chart_rgb(col_q, row_q);
      MODE_BARS: begin
        red_d = {COLOR_BITS{bar_c.r}};
        grn_d = {COLOR_BITS{bar_c.g}};
        blu_d = {COLOR_BITS{bar_c.b}};
      end
      MODE_CHECKER: begin
        if (col_q[0] ^ row_q[0]) begin
          red_d = FULL;
          grn_d = FULL;
          blu_d = FULL;
        end
      end
      default:     {red_d, grn_d, blu_d} = chart_rgb(8'(scroll_col_c), row_q);
    endcase
    if (!active1_q) begin
      red_d = '0;
      grn_d = '0;
      blu_d = '0;
    end
`ifdef VGA_PATTERN_BORDER_EN
    if (active1_q && border1_q) begin
      red_d = FULL;
      grn_d = FULL;
      blu_d = FULL;
    end
`endif
  end

  always_ff @(posedge i_Clk) begin
    if (w_Reset) begin
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
    end else begin
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
    end
  end

  assign bus.o_Red   = red_q;
  assign bus.o_Grn   = grn_q;
  assign bus.o_Blu   = blu_q;
  assign bus.o_Col   = col_q;
  assign bus.o_Row   = row_q;
  assign bus.o_Mode  = mode_q;
  assign bus.o_Frame = frame_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: table of directed pixels plus
// hand-written reset, mode-load timing and scroll/frame-rollover sequences.
module tb_vga_pattern_gen;
  localparam int CB = 3;
`ifdef VGA_PATTERN_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_pattern_gen_if #(.COLOR_BITS(CB), .COORD_BITS(12)) bus ();

  vga_pattern_gen #(
    .COLOR_BITS(CB), .COORD_BITS(12), .H_ACTIVE(640), .V_ACTIVE(480),
    .TILE_W(20), .TILE_H(30)
  ) dut (
    .i_Clk   (clk),
    .w_Reset (rst),
    .bus     (bus)
  );

  typedef struct {
    int mode; int x; int y;
    int col;  int row;
    int r;    int g; int b;
  } vec_t;

  vec_t       vecs[$];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_frame;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Present one coordinate for one clock, then sit 1 time unit after the edge
  task automatic drive(input int x, input int y, input bit load, input int mode);
    bus.i_X         = 12'(x);
    bus.i_Y         = 12'(y);
    bus.i_Mode_Load = load;
    bus.i_Mode      = 2'(mode);
    @(posedge clk);
    #1;
    if (!rst && x == 0 && y == 0) exp_frame++;
  endtask

  // Scan from frame start down column 0 to line y, then along line y to x
  task automatic walk_to(input int x, input int y);
    for (int r = 0; r <= y; r++) drive(0, r, 1'b0, 0);
    for (int c = 1; c <= x; c++) drive(c, y, 1'b0, 0);
  endtask

  function automatic bit on_border(input int x, input int y);
    bit edge_px;
    edge_px = (x < 640) && (y < 480) && (x == 0 || x == 639 || y == 0 || y == 479);
    return BORDER_EN && edge_px;
  endfunction

  task automatic check_rgb(input string tag, input int x, input int y,
                           input int r, input int g, input int b);
    int er, eg, eb;
    er = r; eg = g; eb = b;
    if (on_border(x, y)) begin er = 7; eg = 7; eb = 7; end
    check({tag, "_red"}, int'(bus.o_Red), er);
    check({tag, "_grn"}, int'(bus.o_Grn), eg);
    check({tag, "_blu"}, int'(bus.o_Blu), eb);
  endtask

  // Reset held 3 cycles mid-line with a mode strobe present; reset must win
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(300, 100, 1'b1, 3);
    check("rst_red",   int'(bus.o_Red),   0);
    check("rst_grn",   int'(bus.o_Grn),   0);
    check("rst_blu",   int'(bus.o_Blu),   0);
    check("rst_col",   int'(bus.o_Col),   0);
    check("rst_row",   int'(bus.o_Row),   0);
    check("rst_mode",  int'(bus.o_Mode),  0);
    check("rst_frame", int'(bus.o_Frame), 0);
    rst       = 1'b0;
    exp_frame = 8'd0;
    drive(0, 0, 1'b0, 0);
    check("rel_col",   int'(bus.o_Col),   0);
    check("rel_row",   int'(bus.o_Row),   0);
    check("rel_frame", int'(bus.o_Frame), 1);
    check("rel_mode",  int'(bus.o_Mode),  0);
    drive(700, 700, 1'b0, 0);
    check_rgb("rel", 0, 0, 0, 0, 7);
  endtask

  initial begin
    //                mode  x    y   col row  r  g  b
    vecs.push_back('{0,  25,  35,  1,  1, 0, 1, 6});
    vecs.push_back('{0, 180, 270,  9,  9, 1, 7, 1});
    vecs.push_back('{0, 100, 130,  5,  4, 0, 5, 3});
    vecs.push_back('{0, 250,  60, 12,  2, 0, 3, 2});
    vecs.push_back('{0, 350, 100, 17,  3, 0, 3, 3});
    vecs.push_back('{0, 500, 300, 25, 10, 2, 0, 6});
    vecs.push_back('{0,  60, 400,  3, 13, 5, 3, 0});
    vecs.push_back('{0, 300, 250, 15,  8, 0, 7, 7});
    vecs.push_back('{0, 639,  10, 31,  0, 0, 7, 0});
    vecs.push_back('{0, 700,  10, 35,  0, 0, 0, 0});
    vecs.push_back('{1, 100,  10,  5,  0, 7, 7, 0});
    vecs.push_back('{1, 620,  10, 31,  0, 0, 0, 0});
    vecs.push_back('{1, 200,   5, 10,  0, 0, 7, 7});
    vecs.push_back('{1, 360,   5, 18,  0, 7, 0, 7});
    vecs.push_back('{1, 100, 500,  5, 16, 0, 0, 0});
    vecs.push_back('{2,  20,   0,  1,  0, 7, 7, 7});
    vecs.push_back('{2,  40,  30,  2,  1, 7, 7, 7});
    vecs.push_back('{2,  40,  60,  2,  2, 0, 0, 0});
    vecs.push_back('{2, 639, 479, 31, 15, 0, 0, 0});

    exp_frame = 8'd0;
    do_reset();

    // Table: load mode in blanking, scan to the pixel, check stage 1 then colour
    foreach (vecs[i]) begin
      drive(700, 700, 1'b1, vecs[i].mode);
      walk_to(vecs[i].x, vecs[i].y);
      check($sformatf("v%0d_col", i),   int'(bus.o_Col),   vecs[i].col);
      check($sformatf("v%0d_row", i),   int'(bus.o_Row),   vecs[i].row);
      check($sformatf("v%0d_mode", i),  int'(bus.o_Mode),  vecs[i].mode);
      check($sformatf("v%0d_frame", i), int'(bus.o_Frame), int'(exp_frame));
      drive(700, 700, 1'b0, 0);
      check_rgb($sformatf("v%0d", i), vecs[i].x, vecs[i].y,
                vecs[i].r, vecs[i].g, vecs[i].b);
    end

    // Mode load mid-frame is deferred to the next frame start
    drive(700, 700, 1'b1, 1);
    drive(0, 0, 1'b0, 0);
    check("ml_base", int'(bus.o_Mode), 1);
    drive(400, 200, 1'b1, 2);
    check("ml_hold0", int'(bus.o_Mode), 1);
    drive(401, 200, 1'b0, 0);
    drive(402, 200, 1'b0, 0);
    check("ml_hold1", int'(bus.o_Mode), 1);
    drive(0, 0, 1'b0, 0);
    check("ml_apply", int'(bus.o_Mode), 2);
    // Strobe on the frame-start cycle applies one frame later
    drive(0, 0, 1'b1, 0);
    check("ml_fs_same", int'(bus.o_Mode), 2);
    drive(700, 700, 1'b0, 0);
    drive(0, 0, 1'b0, 0);
    check("ml_fs_next", int'(bus.o_Mode), 0);
    // Last strobe before frame start wins
    drive(10, 10, 1'b1, 3);
    drive(11, 10, 1'b1, 1);
    drive(0, 0, 1'b0, 0);
    check("ml_last", int'(bus.o_Mode), 1);

    // Scroll: fresh reset, mode 3, frame 8 -> offset 2 at pixel (0,0)
    do_reset();
    drive(700, 700, 1'b1, 3);
    for (int i = 0; i < 7; i++) drive(0, 0, 1'b0, 0);
    check("sc_frame8", int'(bus.o_Frame), 8);
    check("sc_mode",   int'(bus.o_Mode),  3);
    drive(700, 700, 1'b0, 0);
    check_rgb("sc_f8", 0, 0, 0, 2, 7);

    // Frame counter rollover with scroll colour at 254, 255, 0
    while (exp_frame != 8'd253) drive(0, 0, 1'b0, 0);
    drive(0, 0, 1'b0, 0);
    check("roll_254", int'(bus.o_Frame), 254);
    drive(700, 700, 1'b0, 0);
    check_rgb("roll_c254", 0, 0, 0, 7, 0);
    drive(0, 0, 1'b0, 0);
    check("roll_255", int'(bus.o_Frame), 255);
    drive(700, 700, 1'b0, 0);
    check_rgb("roll_c255", 0, 0, 0, 7, 0);
    drive(0, 0, 1'b0, 0);
    check("roll_0", int'(bus.o_Frame), 0);
    drive(700, 700, 1'b0, 0);
    check_rgb("roll_c0", 0, 0, 0, 0, 7);
    check("roll_hold", int'(bus.o_Frame), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised multi-mode VGA test-pattern generator; successor to the fixed 8x32 colour-chart logic in the top level.
- Consumes pixel coordinates from VGA_Controller, one pixel per i_Clk.
- Produces registered RGB (COLOR_BITS per channel) with fixed 2-cycle latency.
- Tile row/col come from counters, not dividers. Mode changes apply only at frame start; a frame counter drives a scrolling mode.

Parameters:
COLOR_BITS, 3, bits per colour channel; M = 2^COLOR_BITS-1 is full scale
COORD_BITS, 12, width of i_X/i_Y
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
TILE_W, 20, pixels per tile column (>=2)
TILE_H, 30, lines per tile row (>=2)

Ports:
i_Clk  in  1  pixel clock
w_Reset  in  1  synchronous, active-high reset
i_X  in  COORD_BITS  current pixel column from VGA_Controller
i_Y  in  COORD_BITS  current line from VGA_Controller
i_Mode  in  2  requested mode: 0 CHART, 1 BARS, 2 CHECKER, 3 SCROLL
i_Mode_Load  in  1  1-cycle strobe; captures i_Mode into pending register
o_Red/o_Grn/o_Blu  out  COLOR_BITS each  pixel colour
o_Col  out  8  current tile column (stage-1 value)
o_Row  out  8  current tile row (stage-1 value)
o_Mode  out  2  mode currently applied
o_Frame  out  8  frame counter

Behaviour:
- Reset (sync, w_Reset, i_Clk): all outputs 0, pending mode 0, tile sub-counters 0, pipeline valid bits 0. Reset wins over every other event in the same cycle.
- Stage 1 (registered):
  - i_X==0: col=0, px=0.
  - Otherwise px increments; at px==TILE_W-1, px=0 and col++ (8-bit, wraps).
  - At i_X==0: if i_Y==0, row=0 and py=0; else py increments, and at py==TILE_H-1, py=0 and row++.
  - active1 = (i_X<H_ACTIVE)&&(i_Y<V_ACTIVE).
- Frame start = (i_X==0 && i_Y==0), decoded in stage 1. On it: o_Mode<=pending, o_Frame++ (wraps 255->0).
- i_Mode_Load on the frame-start cycle: the new value is captured into pending and is not applied until the next frame. The last strobe before frame start wins.
- Stage 2 (registered colour), with lo=col[COLOR_BITS-1:0], lr=row[COLOR_BITS-1:0], band=col[COLOR_BITS+1:COLOR_BITS], half=row[COLOR_BITS]:
  - CHART, half=0:
    - band0: R=0, G=lo, B=~lr
    - band1: R=0, G=~lo, B=lr
    - band2: R=0, G=lr, B=lr
    - band3: R=0, G=~lr, B=~lo
  - CHART, half=1:
    - band0: R=lr, G=lo, B=0
    - band1: R=lr, G=M, B=lo
    - band2: R=lr, G=~lo, B=M
    - band3: R=lr, G=0, B=~lo
  - CHART bounds: row>=2^(COLOR_BITS+1) or col>=2^(COLOR_BITS+2) gives black.
  - BARS: b=col[4:2]; R={COLOR_BITS{~b[1]}}, G={COLOR_BITS{~b[2]}}, B={COLOR_BITS{~b[0]}}. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - CHECKER: col[0]^row[0] gives all M, else all 0.
  - SCROLL: CHART with col replaced by (col + o_Frame[7:2]) mod 2^(COLOR_BITS+2).
- active1==0 forces colour 0 in stage 2.
- Latency: coordinate presented in cycle N gives colour at N+2. o_Col/o_Row correspond to cycle N+1.

Optional Feature:
Macro VGA_PATTERN_BORDER_EN.
- Defined: stage 2 forces all channels to M when the pixel is active and X==0, X==H_ACTIVE-1, Y==0 or Y==V_ACTIVE-1. Stage 1 carries the border flag alongside active1. This overrides every mode; latency is unchanged.
- Undefined: no border logic; pattern only.

Decomposition:
- Package vga_pattern_pkg:
  - mode encodings MODE_CHART/BARS/CHECKER/SCROLL
  - helper function colour_max(COLOR_BITS)
  - bar-colour constants
- Sub-module vga_tile_counter (parameters TILE_SIZE, COUNT_W): instantiated once for columns (advance every pixel, clear at X==0) and once for rows (advance at X==0, clear at Y==0).

Test Plan:
1. Reset held 3 cycles mid-line (X=300) -> all outputs 0. After release with X=0,Y=0: o_Col=0, o_Row=0, o_Frame=1 at N+1.
2. CHART, coordinate (X=25,Y=35) -> col=1, row=1 -> at N+2: R=0, G=1, B=6. (X=180,Y=270) -> col=9, row=9, band1 half1 -> R=1, G=7, B=1.
3. BARS, X=100 (col=5, b=1) -> yellow: R=7, G=7, B=0. X=620 (col=31, b=7) -> 0,0,0.
4. i_Mode_Load with i_Mode=2 at (X=400,Y=200) -> o_Mode unchanged until the next X=0,Y=0, then 2. A strobe exactly on the frame-start cycle -> applies one frame later.
5. X=700 (blanking) in any mode -> RGB=0. With VGA_PATTERN_BORDER_EN: X=639,Y=10 -> RGB=7,7,7.
6. SCROLL, o_Frame=8 (offset 2), X=0,Y=0 -> colour equals CHART at col=2,row=0 (R=0, G=2, B=7). o_Frame rolls 255 -> 0 without glitch.
